rs_alu_param: RTL and testbench
===============================

// Module: rs_alu_param
// PURPOSE
//  Parametrised ALU reservation station; successor to the fixed single-bus RSALU.
//  Sits between dispatch (operand managers / RAT / ROB lookups) and the ALU.
//  Holds DEPTH renamed ops and snoops NUM_CDB result buses to wake up pending operands.
//  Issues the oldest ready op to the ALU through a registered valid/ready port.
//  Supports rollback flush.
// PARAMETERS
//  DEPTH     4                   number of RS entries (>=2)
//  DATA_W    32                  operand/result width
//  TAG_W     `ROB_ENTRY_WIDTH    ROB index width (Qj/Qk/Dest)
//  OP_W      4                   ALU opcode width (ALUCtrl)
//  NUM_CDB   2                   number of CDB broadcast channels
//  CNT_W     $clog2(DEPTH+1)     occupancy counter width
// PORTS
//  clk        in   1                 clock; all state on rising edge
//  rst        in   1                 asynchronous, active-low reset
//  flush      in   1                 rollback: synchronous clear of all entries and of the issue register
//  issue_we   in   1                 dispatch write request
//  Op_in      in   OP_W              ALU opcode
//  Vj_in      in   DATA_W            operand A value; valid when Qj_busy_in=0
//  Vk_in      in   DATA_W            operand B value; valid when Qk_busy_in=0
//  Qj_busy_in in   1                 operand A still pending on ROB tag Qj_in
//  Qk_busy_in in   1                 operand B still pending on ROB tag Qk_in
//  Qj_in      in   TAG_W             producer tag of operand A
//  Qk_in      in   TAG_W             producer tag of operand B
//  Dest_in    in   TAG_W             destination ROB index
//  full       out  1                 count==DEPTH
//  count      out  CNT_W             number of valid entries
//  cdb_valid  in   NUM_CDB           per-channel broadcast valid
//  cdb_tag    in   NUM_CDB*TAG_W     channel i at [i*TAG_W +: TAG_W]
//  cdb_data   in   NUM_CDB*DATA_W    channel i at [i*DATA_W +: DATA_W]
//  fu_ready   in   1                 ALU accepts the issue register this cycle
//  iss_valid  out  1                 issue register holds an op
//  Op_out     out  OP_W              issued opcode
//  Vj_out     out  DATA_W            issued operand A
//  Vk_out     out  DATA_W            issued operand B
//  Dest_out   out  TAG_W             issued destination ROB index
// BEHAVIOUR
//  Reset (rst=0, async): all entries invalid; count=0; full=0; iss_valid=0; Op/Vj/Vk/Dest_out=0.
//  Storage: compacting queue; entry 0 is the oldest; valid entries are always contiguous 0..count-1.
//  Per entry: Op, Vj, Vk, Qj, Qk, Dest, busyJ, busyK.
//  Ready entry: busyJ=0 and busyK=0, evaluated on registered state.
//  No same-cycle wakeup-to-select bypass.
//  Dispatch:
//    - Accepted when issue_we=1 and full=0 at the clock edge.
//    - issue_we while full: dropped silently, no state change.
//    - Written at position count, or count-1 when an issue-side removal happens in the same cycle.
//  Dispatch-time forwarding:
//    - If Qx_busy_in=1 and Qx_in matches a valid CDB channel in the same cycle, the entry captures that data with busy=0.
//  Wakeup: each edge, every valid entry with busyX=1 compares Qx against all valid CDB channels.
//    - On a match: Vx<=data and busyX<=0.
//    - If several channels match the same tag, the lowest channel index wins.
//  Issue register:
//    - load_en = (iss_valid=0) or fu_ready.
//    - When load_en=1 and a ready entry exists: the lowest-index ready entry is moved into the issue register
//      (iss_valid<=1) and entries above it shift down by one.
//    - When load_en=1 and no entry is ready: iss_valid<=0.
//    - When iss_valid=1 and fu_ready=0: all *_out held stable, no removal.
//  Latency: op dispatched at edge k with both operands ready -> iss_valid=1 after edge k+1 (given load_en).
//    - Pending operand woken at edge k -> issue at edge k+1.
//  Simultaneous events:
//    - Dispatch + issue in the same cycle: count unchanged.
//    - Dispatch when full=1 is refused even if an issue frees a slot that cycle (full is registered-state based).
//  Flush: takes priority over dispatch, wakeup and issue.
//    - Next cycle: count=0, iss_valid=0; outputs keep their values.
//  Widths: count saturates at DEPTH by construction; tags compared at full TAG_W; no tag-0 special case.
// TESTING
//  T1 reset mid-run with 3 entries -> immediately count=0, full=0, iss_valid=0, outputs 0.
//  T2 dispatch Op=0,Vj=5,Vk=7,Dest=3, both not busy, fu_ready=1 -> after 2 edges iss_valid=1, Vj_out=5, Vk_out=7, Dest_out=3.
//  T3 dispatch busyJ,Qj=2; 3 cycles later cdb ch1 tag=2 data=0x10 -> next edge iss_valid=1, Vj_out=0x10.
//     Also: dispatch busyK,Qk=5 with same-cycle cdb ch0 tag=5 data=0xAB -> captured, Vk_out=0xAB.
//  T4 fill DEPTH=4 entries with busy ops -> full=1; 5th issue_we ignored, count=4.
//     Wake entry 2 via CDB -> it issues, count=3, order of the rest preserved.
//  T5 two ready ops A then B, fu_ready=0 for 3 cycles -> Dest_out=A held stable.
//     fu_ready=1 -> next edge Dest_out=B.
//  T6 flush with count=3 and iss_valid=1, plus issue_we same cycle -> next edge count=0, iss_valid=0, nothing written.

Source files
------------

// File: rtl/rs_alu_param_if.sv
// ---------------------------------------------------------------------------
// rs_alu_param_if
//   Bundles everything the ALU reservation station exchanges with the rest of
//   the core: rollback flush, the dispatch write port, the CDB snoop buses and
//   the registered issue port towards the ALU.
//
//   master : dispatch / CDB / ALU side (drives requests, observes status)
//   slave  : the reservation station itself
//
//   Signals
//     flush                   rollback, clears all entries and the issue reg
//     issue_we, Op_in, Vj_in, Vk_in, Qj_busy_in, Qk_busy_in, Qj_in, Qk_in,
//     Dest_in                 dispatch write port
//     full, count             occupancy status
//     cdb_valid/tag/data      NUM_CDB packed broadcast channels
//     fu_ready                ALU accepts the issue register this cycle
//     iss_valid, Op_out, Vj_out, Vk_out, Dest_out   issue register
//
//   Issue handshake: an op transfers to the ALU on a rising edge where
//   iss_valid=1 and fu_ready=1; while iss_valid=1 and fu_ready=0 every *_out
//   stays stable. fu_ready may be asserted with iss_valid=0 (no transfer).
// ---------------------------------------------------------------------------
interface rs_alu_param_if #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 4,
    parameter int NUM_CDB = 2,
    parameter int CNT_W   = 3
);
    logic                       flush;
    logic                       issue_we;
    logic [OP_W-1:0]            Op_in;
    logic [DATA_W-1:0]          Vj_in;
    logic [DATA_W-1:0]          Vk_in;
    logic                       Qj_busy_in;
    logic                       Qk_busy_in;
    logic [TAG_W-1:0]           Qj_in;
    logic [TAG_W-1:0]           Qk_in;
    logic [TAG_W-1:0]           Dest_in;
    logic                       full;
    logic [CNT_W-1:0]           count;
    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]  cdb_data;
    logic                       fu_ready;
    logic                       iss_valid;
    logic [OP_W-1:0]            Op_out;
    logic [DATA_W-1:0]          Vj_out;
    logic [DATA_W-1:0]          Vk_out;
    logic [TAG_W-1:0]           Dest_out;

    modport master (
        output flush, issue_we, Op_in, Vj_in, Vk_in, Qj_busy_in, Qk_busy_in,
               Qj_in, Qk_in, Dest_in, cdb_valid, cdb_tag, cdb_data, fu_ready,
        input  full, count, iss_valid, Op_out, Vj_out, Vk_out, Dest_out
    );

    modport slave (
        input  flush, issue_we, Op_in, Vj_in, Vk_in, Qj_busy_in, Qk_busy_in,
               Qj_in, Qk_in, Dest_in, cdb_valid, cdb_tag, cdb_data, fu_ready,
        output full, count, iss_valid, Op_out, Vj_out, Vk_out, Dest_out
    );
endinterface

// File: rtl/rs_alu_param.sv
// ---------------------------------------------------------------------------
// rs_alu_param
//   Parametrised ALU reservation station. Holds DEPTH renamed ops in a
//   compacting queue (entry 0 oldest, valid entries 0..count-1), snoops
//   NUM_CDB result buses to wake pending operands, and moves the oldest ready
//   op into a registered issue port towards the ALU.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   rs_alu_param_if.slave (dispatch, CDB, issue port, status)
// ---------------------------------------------------------------------------
module rs_alu_param #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 4,
    parameter int NUM_CDB = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    rs_alu_param_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    // Registered entry state
    logic [OP_W-1:0]   e_op   [DEPTH];
    logic [DATA_W-1:0] e_vj   [DEPTH];
    logic [DATA_W-1:0] e_vk   [DEPTH];
    logic [TAG_W-1:0]  e_qj   [DEPTH];
    logic [TAG_W-1:0]  e_qk   [DEPTH];
    logic [TAG_W-1:0]  e_dest [DEPTH];
    logic              e_bj   [DEPTH];
    logic              e_bk   [DEPTH];
    logic [CNT_W-1:0]  count_q;

    logic              iss_valid_q;
    logic [OP_W-1:0]   op_out_q;
    logic [DATA_W-1:0] vj_out_q;
    logic [DATA_W-1:0] vk_out_q;
    logic [TAG_W-1:0]  dest_out_q;

    // Entry values after this cycle's wakeup
    logic [DATA_W-1:0] w_vj [DEPTH];
    logic [DATA_W-1:0] w_vk [DEPTH];
    logic              w_bj [DEPTH];
    logic              w_bk [DEPTH];

    // Next entry state after removal and dispatch
    logic [OP_W-1:0]   n_op   [DEPTH];
    logic [DATA_W-1:0] n_vj   [DEPTH];
    logic [DATA_W-1:0] n_vk   [DEPTH];
    logic [TAG_W-1:0]  n_qj   [DEPTH];
    logic [TAG_W-1:0]  n_qk   [DEPTH];
    logic [TAG_W-1:0]  n_dest [DEPTH];
    logic              n_bj   [DEPTH];
    logic              n_bk   [DEPTH];

    // Dispatch operands after same-cycle CDB forwarding
    logic [DATA_W-1:0] d_vj, d_vk;
    logic              d_bj, d_bk;

    logic [DEPTH-1:0]  rdy;
    logic              has_rdy;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  wr_pos;
    logic              full_w, load_en, do_issue, do_disp;

    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign load_en  = !iss_valid_q || bus.fu_ready;
    assign do_issue = load_en && has_rdy && !bus.flush;
    assign do_disp  = bus.issue_we && !full_w && !bus.flush;
    // When an entry leaves in the same cycle the queue compacts first, so the
    // new op lands one slot lower.
    assign wr_pos   = IDX_W'(count_q - CNT_W'(do_issue));

    // Readiness uses registered busy bits only: a wakeup this cycle cannot
    // be selected until the next one.
    always_comb begin
        rdy     = '0;
        has_rdy = 1'b0;
        sel     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = (CNT_W'(i) < count_q) && !e_bj[i] && !e_bk[i];
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[i]) begin
                has_rdy = 1'b1;
                sel     = IDX_W'(i);
            end
        end
    end

    // Wakeup and dispatch forwarding; channels scanned high to low so the
    // lowest matching channel index is the last assignment and wins.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_vj[i] = e_vj[i];
            w_vk[i] = e_vk[i];
            w_bj[i] = e_bj[i];
            w_bk[i] = e_bk[i];
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (e_bj[i] && bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == e_qj[i]) begin
                    w_vj[i] = bus.cdb_data[c*DATA_W +: DATA_W];
                    w_bj[i] = 1'b0;
                end
                if (e_bk[i] && bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == e_qk[i]) begin
                    w_vk[i] = bus.cdb_data[c*DATA_W +: DATA_W];
                    w_bk[i] = 1'b0;
                end
            end
        end
        d_vj = bus.Vj_in;
        d_vk = bus.Vk_in;
        d_bj = bus.Qj_busy_in;
        d_bk = bus.Qk_busy_in;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (bus.Qj_busy_in && bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == bus.Qj_in) begin
                d_vj = bus.cdb_data[c*DATA_W +: DATA_W];
                d_bj = 1'b0;
            end
            if (bus.Qk_busy_in && bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == bus.Qk_in) begin
                d_vk = bus.cdb_data[c*DATA_W +: DATA_W];
                d_bk = 1'b0;
            end
        end
    end

    // Compaction: entries at or above the issued slot take their upper
    // neighbour; the top slot keeps stale data, which count marks invalid.
    always_comb begin
        logic [IDX_W-1:0] src;
        for (int i = 0; i < DEPTH; i++) begin
            src = (do_issue && IDX_W'(i) >= sel && i < DEPTH - 1) ? IDX_W'(i + 1) : IDX_W'(i);
            n_op[i]   = e_op[src];
            n_vj[i]   = w_vj[src];
            n_vk[i]   = w_vk[src];
            n_qj[i]   = e_qj[src];
            n_qk[i]   = e_qk[src];
            n_dest[i] = e_dest[src];
            n_bj[i]   = w_bj[src];
            n_bk[i]   = w_bk[src];
        end
        if (do_disp) begin
            n_op[wr_pos]   = bus.Op_in;
            n_vj[wr_pos]   = d_vj;
            n_vk[wr_pos]   = d_vk;
            n_qj[wr_pos]   = bus.Qj_in;
            n_qk[wr_pos]   = bus.Qk_in;
            n_dest[wr_pos] = bus.Dest_in;
            n_bj[wr_pos]   = d_bj;
            n_bk[wr_pos]   = d_bk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_op[i]   <= '0;
                e_vj[i]   <= '0;
                e_vk[i]   <= '0;
                e_qj[i]   <= '0;
                e_qk[i]   <= '0;
                e_dest[i] <= '0;
                e_bj[i]   <= 1'b0;
                e_bk[i]   <= 1'b0;
            end
            count_q     <= '0;
            iss_valid_q <= 1'b0;
            op_out_q    <= '0;
            vj_out_q    <= '0;
            vk_out_q    <= '0;
            dest_out_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                e_op[i]   <= n_op[i];
                e_vj[i]   <= n_vj[i];
                e_vk[i]   <= n_vk[i];
                e_qj[i]   <= n_qj[i];
                e_qk[i]   <= n_qk[i];
                e_dest[i] <= n_dest[i];
                e_bj[i]   <= n_bj[i];
                e_bk[i]   <= n_bk[i];
            end
            if (bus.flush) begin
                // Outputs intentionally keep their last values.
                count_q     <= '0;
                iss_valid_q <= 1'b0;
            end else begin
                count_q <= count_q + CNT_W'(do_disp) - CNT_W'(do_issue);
                if (load_en) begin
                    iss_valid_q <= has_rdy;
                end
                if (do_issue) begin
                    op_out_q   <= e_op[sel];
                    vj_out_q   <= e_vj[sel];
                    vk_out_q   <= e_vk[sel];
                    dest_out_q <= e_dest[sel];
                end
            end
        end
    end

    assign bus.full      = full_w;
    assign bus.count     = count_q;
    assign bus.iss_valid = iss_valid_q;
    assign bus.Op_out    = op_out_q;
    assign bus.Vj_out    = vj_out_q;
    assign bus.Vk_out    = vk_out_q;
    assign bus.Dest_out  = dest_out_q;
endmodule

// File: tb/tb_rs_alu_param.sv
module tb_rs_alu_param;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int OW    = 4;
    localparam int NC    = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = OW + 2 * DW + TW;

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] vj;
        logic [DW-1:0] vk;
        logic [TW-1:0] qj;
        logic [TW-1:0] qk;
        logic [TW-1:0] dest;
        logic          bj;
        logic          bk;
    } ent_t;

    logic clk;
    logic rst;

    rs_alu_param_if #(.DATA_W(DW), .TAG_W(TW), .OP_W(OW), .NUM_CDB(NC), .CNT_W(CW)) bus ();

    rs_alu_param #(.DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .OP_W(OW), .NUM_CDB(NC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    ent_t m_q[$];
    logic m_iv = 1'b0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic ent_t wake_ent(input ent_t e);
        ent_t r = e;
        for (int c = 0; c < NC; c++) begin
            if (r.bj && bus.cdb_valid[c] && bus.cdb_tag[c*TW +: TW] == r.qj) begin
                r.vj = bus.cdb_data[c*DW +: DW];
                r.bj = 1'b0;
            end
            if (r.bk && bus.cdb_valid[c] && bus.cdb_tag[c*TW +: TW] == r.qk) begin
                r.vk = bus.cdb_data[c*DW +: DW];
                r.bk = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic model_update();
        int   idx;
        int   old_n;
        logic ld;
        ent_t e;
        if (bus.flush) begin
            if (m_iv && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
            m_q.delete();
            m_iv = 1'b0;
            return;
        end
        ld    = !m_iv || bus.fu_ready;
        old_n = m_q.size();
        idx   = -1;
        for (int i = 0; i < old_n; i++) begin
            if (idx < 0 && !m_q[i].bj && !m_q[i].bk) idx = i;
        end
        if (ld && idx >= 0) begin
            e = m_q[idx];
            exp_q.push_back({e.op, e.vj, e.vk, e.dest});
            m_q.delete(idx);
        end
        if (ld) m_iv = (idx >= 0);
        for (int i = 0; i < m_q.size(); i++) m_q[i] = wake_ent(m_q[i]);
        if (bus.issue_we && old_n < DEPTH) begin
            e.op   = bus.Op_in;
            e.vj   = bus.Vj_in;
            e.vk   = bus.Vk_in;
            e.qj   = bus.Qj_in;
            e.qk   = bus.Qk_in;
            e.dest = bus.Dest_in;
            e.bj   = bus.Qj_busy_in;
            e.bk   = bus.Qk_busy_in;
            m_q.push_back(wake_ent(e));
        end
    endtask

    // ---------------- monitor: pops on every accepted issue ----------------
    always @(negedge clk) begin
        if (rst && bus.iss_valid && bus.fu_ready && !bus.flush) begin
            if (exp_q.size() == 0) chk("issue_unexpected", 1, 0);
            else chk("issue_data", {bus.Op_out, bus.Vj_out, bus.Vk_out, bus.Dest_out}, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input logic fr);
        bus.flush      = 1'b0;
        bus.issue_we   = 1'b0;
        bus.Op_in      = '0;
        bus.Vj_in      = '0;
        bus.Vk_in      = '0;
        bus.Qj_busy_in = 1'b0;
        bus.Qk_busy_in = 1'b0;
        bus.Qj_in      = '0;
        bus.Qk_in      = '0;
        bus.Dest_in    = '0;
        bus.cdb_valid  = '0;
        bus.cdb_tag    = '0;
        bus.cdb_data   = '0;
        bus.fu_ready   = fr;
    endtask

    task automatic disp(input logic [OW-1:0] op, input logic [DW-1:0] vj, input logic [DW-1:0] vk,
                        input logic bj, input logic [TW-1:0] qj, input logic bk, input logic [TW-1:0] qk,
                        input logic [TW-1:0] dest);
        bus.issue_we   = 1'b1;
        bus.Op_in      = op;
        bus.Vj_in      = vj;
        bus.Vk_in      = vk;
        bus.Qj_busy_in = bj;
        bus.Qj_in      = qj;
        bus.Qk_busy_in = bk;
        bus.Qk_in      = qk;
        bus.Dest_in    = dest;
    endtask

    task automatic cdb(input int c, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        bus.cdb_valid[c]          = 1'b1;
        bus.cdb_tag[c*TW +: TW]   = tag;
        bus.cdb_data[c*DW +: DW]  = data;
    endtask

    // Inputs are already driven; model this edge, then check status after it.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("count", EW'(bus.count), EW'(m_q.size()));
        chk("full", EW'(bus.full), EW'(m_q.size() == DEPTH));
        chk("iss_valid", EW'(bus.iss_valid), EW'(m_iv));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, EW'(bus.count), 0);
        chk({tag, "_full"}, EW'(bus.full), 0);
        chk({tag, "_iss_valid"}, EW'(bus.iss_valid), 0);
        chk({tag, "_outs"}, {bus.Op_out, bus.Vj_out, bus.Vk_out, bus.Dest_out}, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b0;
        idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // T2: ready op issues two edges after dispatch
        idle(1'b1);
        disp(4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        step();
        chk("t2_not_yet", EW'(bus.iss_valid), 0);
        idle(1'b1);
        step();
        chk("t2_iss_valid", EW'(bus.iss_valid), 1);
        chk("t2_vj", EW'(bus.Vj_out), 5);
        chk("t2_vk", EW'(bus.Vk_out), 7);
        chk("t2_dest", EW'(bus.Dest_out), 3);

        // T3: late wakeup on channel 1, then dispatch-time forwarding on channel 0
        idle(1'b1);
        disp(4'd2, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd6);
        step();
        repeat (3) begin
            idle(1'b1);
            step();
        end
        idle(1'b1);
        cdb(1, 4'd2, 32'h10);
        step();
        chk("t3_no_bypass", EW'(bus.iss_valid), 0);
        idle(1'b1);
        step();
        chk("t3_iss_valid", EW'(bus.iss_valid), 1);
        chk("t3_vj", EW'(bus.Vj_out), 32'h10);
        chk("t3_dest", EW'(bus.Dest_out), 6);
        idle(1'b1);
        disp(4'd3, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd7);
        cdb(0, 4'd5, 32'hAB);
        step();
        idle(1'b1);
        step();
        chk("t3_fwd_vk", EW'(bus.Vk_out), 32'hAB);
        chk("t3_fwd_dest", EW'(bus.Dest_out), 7);

        // T5: stall holds the issue register, then the next op follows
        idle(1'b1);
        step();
        idle(1'b0);
        disp(4'd1, 32'd11, 32'd12, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
        step();
        idle(1'b0);
        disp(4'd1, 32'd21, 32'd22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd11);
        step();
        repeat (3) begin
            idle(1'b0);
            step();
            chk("t5_hold_dest", EW'(bus.Dest_out), 10);
        end
        idle(1'b1);
        step();
        chk("t5_next_dest", EW'(bus.Dest_out), 11);
        idle(1'b1);
        step();

        // T4: fill with pending ops, overflow dropped, out-of-order wakeup
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b1);
            disp(4'd5, 32'd0, 32'(100 + i), 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(1 + i));
            step();
        end
        chk("t4_full", EW'(bus.full), 1);
        idle(1'b1);
        disp(4'd6, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15);
        step();
        chk("t4_drop_count", EW'(bus.count), 4);
        idle(1'b1);
        cdb(1, 4'd10, 32'h222);
        step();
        idle(1'b1);
        step();
        chk("t4_count3", EW'(bus.count), 3);
        chk("t4_dest_e2", EW'(bus.Dest_out), 3);
        chk("t4_vj_e2", EW'(bus.Vj_out), 32'h222);
        idle(1'b1);
        cdb(0, 4'd8, 32'h111);
        cdb(1, 4'd11, 32'h444);
        step();
        idle(1'b1);
        cdb(0, 4'd9, 32'h333);
        step();
        chk("t4_order0", EW'(bus.Dest_out), 1);
        idle(1'b1);
        step();
        chk("t4_order1", EW'(bus.Dest_out), 2);
        idle(1'b1);
        step();
        chk("t4_order2", EW'(bus.Dest_out), 4);
        idle(1'b1);
        step();

        // T6: flush beats dispatch and issue
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            disp(4'(i), 32'(i), 32'(i + 1), 1'b0, 4'd0, 1'b0, 4'd0, 4'(1 + i));
            step();
        end
        chk("t6_pre_count", EW'(bus.count), 3);
        chk("t6_pre_iss", EW'(bus.iss_valid), 1);
        idle(1'b1);
        bus.flush = 1'b1;
        disp(4'd9, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        step();
        chk("t6_count", EW'(bus.count), 0);
        chk("t6_iss", EW'(bus.iss_valid), 0);
        idle(1'b0);
        step();
        chk("t6_nothing_written", EW'(bus.count), 0);

        // T1: asynchronous reset with three entries
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            disp(4'd7, 32'd1, 32'd2, 1'b1, 4'(12 + i), 1'b0, 4'd0, 4'(5 + i));
            step();
        end
        chk("t1_pre_count", EW'(bus.count), 3);
        rst = 1'b0;
        #1;
        chk_reset_outputs("t1");
        m_q.delete();
        m_iv = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            idle($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6) begin
                disp(OW'($urandom_range(0, 15)), $urandom, $urandom,
                     1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)),
                     TW'($urandom_range(0, 15)));
            end
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 2) == 0) cdb(c, TW'($urandom_range(0, 3)), $urandom);
            end
            bus.flush = ($urandom_range(0, 49) == 0);
            step();
        end

        // Drain: broadcast every tag in rotation until the station empties
        for (int n = 0; n < 16; n++) begin
            idle(1'b1);
            cdb(0, TW'(n % 4), $urandom);
            cdb(1, TW'((n + 1) % 4), $urandom);
            step();
        end
        chk("drain_count", EW'(bus.count), 0);
        chk("drain_iss", EW'(bus.iss_valid), 0);
        chk("drain_scoreboard", EW'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
